comparator_sort_ctrl: RTL and testbench

Sequential bubble-sort controller built around one shared 4-bit comparator instance. Accepts DEPTH 4-bit values serially and sorts them in place, ascending, using one compare per clock. Then streams the sorted values out serially. Sits between a 4-bit producer (switches/ROM) and a consumer (display or next lab stage); the comparator is the only magnitude-compare resource.

---
 rtl/comparator_sort_pkg.sv | 17 +
 rtl/comparator_sort_ctrl_cmp.sv | 16 +
 rtl/comparator_sort_ctrl.sv | 129 ++++++++++++
 tb/tb_comparator_sort_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_sort_pkg.sv
// rtl/comparator_sort_pkg.sv - shared state encoding, data width and pointer sizing for the sort controller
package comparator_sort_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Index width for DEPTH entries, never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/comparator_sort_ctrl_cmp.sv
// rtl/comparator_sort_ctrl_cmp.sv - unsigned 4-bit magnitude comparator shared by the sort datapath
module comparator_sort_ctrl_cmp
    import comparator_sort_pkg::*;
(
    input  logic [DATA_W-1:0] f,
    input  logic [DATA_W-1:0] s,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    assign gt = (f > s);
    assign lt = (f < s);
    assign eq = (f == s);

endmodule

// File: rtl/comparator_sort_ctrl.sv
// rtl/comparator_sort_ctrl.sv - serial load, one-compare-per-cycle bubble sort, serial unload
// Optional: COMPARATOR_SORT_EARLY_EXIT_EN ends SORT after the first pass with no swaps.
module comparator_sort_ctrl
    import comparator_sort_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(DEPTH - 2);

    state_t            state;
    logic [DATA_W-1:0] entry [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     j;
    logic [PW-1:0]     pass;
    logic              swapped;

    logic [PW-1:0]     j_next;
    logic [PW-1:0]     j_last;
    logic              cmp_gt;
    logic              cmp_lt;
    logic              cmp_eq;
    logic              swap_seen;
    logic              pass_end;
    logic              sort_done;
    logic              cmp_unused;

    comparator_sort_ctrl_cmp u_cmp (
        .f  (entry[j]),
        .s  (entry[j_next]),
        .gt (cmp_gt),
        .lt (cmp_lt),
        .eq (cmp_eq)
    );

    // lt/eq are kept on the comparator for debug probing only.
    assign cmp_unused = cmp_lt ^ cmp_eq;

    assign j_next    = j + 1'b1;
    assign j_last    = LAST_PASS - pass;
    assign swap_seen = swapped | cmp_gt;
    assign pass_end  = (j == j_last);

`ifdef COMPARATOR_SORT_EARLY_EXIT_EN
    assign sort_done = pass_end && ((pass == LAST_PASS) || !swap_seen);
`else
    assign sort_done = pass_end && (pass == LAST_PASS);
`endif

    assign in_ready  = (state == S_LOAD);
    assign busy      = (state == S_SORT);
    assign out_valid = (state == S_OUT);
    assign out_data  = (state == S_OUT) ? entry[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        entry[wr_ptr] <= in_data;
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr  <= '0;
                            j       <= '0;
                            pass    <= '0;
                            swapped <= 1'b0;
                            state   <= S_SORT;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    // Strict greater-than only, so equal keys keep their order.
                    if (cmp_gt) begin
                        entry[j]      <= entry[j_next];
                        entry[j_next] <= entry[j];
                    end
                    if (pass_end) begin
                        j       <= '0;
                        pass    <= pass + 1'b1;
                        swapped <= 1'b0;
                        if (sort_done) begin
                            pass  <= '0;
                            state <= S_OUT;
                        end
                    end else begin
                        j       <= j_next;
                        swapped <= swap_seen;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            state  <= S_LOAD;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// tb/tb_comparator_sort_ctrl.sv - randomized self-checking bench for comparator_sort_ctrl (DEPTH 4 and 2)
module tb_comparator_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready = 1'b0;
    logic       busy;

    logic       in_valid2 = 1'b0;
    logic [3:0] in_data2 = '0;
    logic       in_ready2;
    logic       out_valid2;
    logic [3:0] out_data2;
    logic       out_ready2 = 1'b0;
    logic       busy2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    comparator_sort_ctrl #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
    );

    comparator_sort_ctrl #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2), .busy(busy2)
    );

    // Bubble sort needs as many swapping passes as the largest count of greater
    // values sitting before any element; early exit adds one clean pass.
    function automatic int exp_sort_cycles(input int v[$]);
        int d;
        int m;
        int cnt;
        int passes;
        int c;
        d = v.size();
        m = 0;
        for (int i = 0; i < d; i++) begin
            cnt = 0;
            for (int k = 0; k < i; k++) if (v[k] > v[i]) cnt++;
            if (cnt > m) m = cnt;
        end
        passes = d - 1;
`ifdef COMPARATOR_SORT_EARLY_EXIT_EN
        if (m + 1 < passes) passes = m + 1;
`endif
        c = 0;
        for (int p = 0; p < passes; p++) c += d - 1 - p;
        return c;
    endfunction

    task automatic load4(input int v[$], input int max_gap, input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s load_ready[%0d] got=%0b want=1", tag, i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = 4'(v[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sort_wait4(input int want, input string tag);
        int cnt;
        cnt = 0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s sort_in_ready got=%0b want=0", tag, in_ready);
        end
        while (busy === 1'b1 && cnt < 300) begin
            cnt++;
            // Producer chatter during SORT must be ignored.
            in_valid = 1'($urandom_range(1, 0));
            in_data  = 4'($urandom_range(15, 0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (cnt !== want) begin
            bad++;
            $display("FAIL %s sort_cycles got=%0d want=%0d", tag, cnt, want);
        end
    endtask

    task automatic read4(input int e[$], input int first_stall, input int smin, input int smax,
                         input string tag);
        int st;
        for (int k = 0; k < 4; k++) begin
            st = (k == 0) ? first_stall : $urandom_range(smax, smin);
            out_ready = 1'b0;
            for (int s = 0; s < st; s++) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 4'(e[k])) begin
                    bad++;
                    $display("FAIL %s hold[%0d] got v=%0b d=%0d want v=1 d=%0d", tag, k, out_valid, out_data, e[k]);
                end
                @(negedge clk);
            end
            out_ready = 1'b1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 4'(e[k])) begin
                bad++;
                $display("FAIL %s out[%0d] got v=%0b d=%0d want v=1 d=%0d", tag, k, out_valid, out_data, e[k]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_out got rdy=%0b v=%0b busy=%0b want 1/0/0", tag, in_ready, out_valid, busy);
        end
    endtask

    task automatic run_batch4(input int v[$], input int max_gap, input int first_stall,
                              input int smin, input int smax, input string tag);
        int e[$];
        e = v;
        e.sort();
        load4(v, max_gap, tag);
        sort_wait4(exp_sort_cycles(v), tag);
        read4(e, first_stall, smin, smax, tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset got rdy=%0b v=%0b d=%0d busy=%0b want 1/0/0/0", in_ready, out_valid, out_data, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_batch4('{9, 3, 12, 3}, 0, 0, 0, 0, "dup_9_3_12_3");
        run_batch4('{1, 2, 3, 4}, 0, 0, 0, 1, "presorted");
        run_batch4('{15, 15, 15, 15}, 1, 0, 0, 1, "all_equal");
        run_batch4('{4, 3, 2, 1}, 0, 0, 0, 0, "reversed");
    endtask

    task automatic test_hold();
        run_batch4('{7, 1, 11, 6}, 0, 5, 1, 1, "hold");
    endtask

    task automatic test_reset_mid_sort();
        load4('{8, 7, 6, 5}, 0, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_sort got rdy=%0b v=%0b busy=%0b want 1/0/0", in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_batch4('{4, 0, 2, 1}, 0, 0, 0, 1, "after_rst");
    endtask

    task automatic test_random();
        int v[$];
        for (int b = 0; b < 25; b++) begin
            v = {};
            for (int i = 0; i < 4; i++)
                v.push_back((b % 2 == 0) ? $urandom_range(15, 0) : $urandom_range(3, 0));
            run_batch4(v, 2, $urandom_range(2, 0), 0, 2, "random");
        end
    endtask

    task automatic test_back_to_back();
        int v[$];
        for (int b = 0; b < 6; b++) begin
            v = {};
            for (int i = 0; i < 4; i++) v.push_back($urandom_range(15, 0));
            run_batch4(v, 0, 0, 0, 0, "b2b");
        end
    endtask

    task automatic test_depth2();
        int v[$];
        int e[$];
        int cnt;
        for (int b = 0; b < 6; b++) begin
            if (b == 0) v = '{5, 2};
            else v = '{$urandom_range(15, 0), $urandom_range(15, 0)};
            e = v;
            e.sort();
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                total++;
                if (in_ready2 !== 1'b1) begin
                    bad++;
                    $display("FAIL d2_ready[%0d] got=%0b want=1", i, in_ready2);
                end
                in_valid2 = 1'b1;
                in_data2  = 4'(v[i]);
            end
            @(negedge clk);
            in_valid2 = 1'b0;
            cnt = 0;
            while (busy2 === 1'b1 && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            total++;
            if (cnt !== 1) begin
                bad++;
                $display("FAIL d2_sort_cycles got=%0d want=1", cnt);
            end
            out_ready2 = 1'b1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (out_valid2 !== 1'b1 || out_data2 !== 4'(e[k])) begin
                    bad++;
                    $display("FAIL d2_out[%0d] got v=%0b d=%0d want v=1 d=%0d", k, out_valid2, out_data2, e[k]);
                end
                @(negedge clk);
            end
            out_ready2 = 1'b0;
            total++;
            if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
                bad++;
                $display("FAIL d2_after got rdy=%0b v=%0b want 1/0", in_ready2, out_valid2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid_sort();
        test_random();
        test_back_to_back();
        test_depth2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
